// File: rtl/codec_i2c_pkg.sv
// Shared constants and state types for the codec I2C write sequencer.
// Holds I2C-core register map, command values, status bits and FSM states.
package codec_i2c_pkg;

    // I2C-core register addresses
    localparam logic [3:0] A_PRER_LO = 4'd0;
    localparam logic [3:0] A_PRER_HI = 4'd1;
    localparam logic [3:0] A_CTR     = 4'd2;
    localparam logic [3:0] A_TXR     = 4'd3;
    localparam logic [3:0] A_CR      = 4'd4;
    localparam logic [3:0] A_SR      = 4'd4;

    // Command register values
    localparam logic [7:0] CR_STA_WR = 8'h90;
    localparam logic [7:0] CR_WR     = 8'h10;
    localparam logic [7:0] CR_STO_WR = 8'h50;
    localparam logic [7:0] CR_STO    = 8'h40;
    localparam logic [7:0] CTR_EN    = 8'h80;

    // Status register bit positions
    localparam int SR_TIP   = 1;
    localparam int SR_RXACK = 7;

    // Top-level sequencer states
    typedef enum logic [2:0] {
        INIT_PRER_LO = 3'd0,
        INIT_PRER_HI = 3'd1,
        INIT_CTR     = 3'd2,
        IDLE         = 3'd3,
        XFER         = 3'd4,
        ABORT        = 3'd5
    } seq_state_t;

    // Per-byte transfer states
    typedef enum logic [2:0] {
        X_IDLE = 3'd0,
        WR_TXR = 3'd1,
        WR_CR  = 3'd2,
        RD_SR  = 3'd3,
        CHK_SR = 3'd4
    } xfer_state_t;

endpackage

// File: rtl/codec_i2c_byte_xfer.sv
// Sends one byte through the I2C core: TXR write, CR write, SR polling.
// Ports: start/tx_byte/cr in; wr/rd/addr/wdata cmd out; done/nack/timeout.
module codec_i2c_byte_xfer
    import codec_i2c_pkg::*;
#(
    parameter logic [9:0] POLL_LIMIT = 10'd1023
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [7:0] cr,
    input  logic       cmd_done,
    input  logic [7:0] cmd_rdata,
    input  logic       cmd_rdata_valid,
    output logic       wr,
    output logic       rd,
    output logic [3:0] addr,
    output logic [7:0] wdata,
    output logic       done,
    output logic       nack,
    output logic       timeout
);

    xfer_state_t state;
    logic        pend;
    logic [7:0]  byte_q;
    logic [7:0]  cr_q;
    logic        tip_q;
    logic        rxack_q;
    logic [9:0]  poll;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= X_IDLE;
            pend    <= 1'b0;
            byte_q  <= 8'h00;
            cr_q    <= 8'h00;
            tip_q   <= 1'b0;
            rxack_q <= 1'b0;
            poll    <= 10'd0;
            wr      <= 1'b0;
            rd      <= 1'b0;
            addr    <= 4'd0;
            wdata   <= 8'h00;
            done    <= 1'b0;
            nack    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            wr      <= 1'b0;
            rd      <= 1'b0;
            done    <= 1'b0;
            nack    <= 1'b0;
            timeout <= 1'b0;
            unique case (state)
                X_IDLE: begin
                    if (start) begin
                        byte_q <= tx_byte;
                        cr_q   <= cr;
                        poll   <= 10'd0;
                        pend   <= 1'b0;
                        state  <= WR_TXR;
                    end
                end
                WR_TXR: begin
                    // pend gates completions so strays are dropped
                    if (!pend) begin
                        wr    <= 1'b1;
                        addr  <= A_TXR;
                        wdata <= byte_q;
                        pend  <= 1'b1;
                    end else if (cmd_done) begin
                        pend  <= 1'b0;
                        state <= WR_CR;
                    end
                end
                WR_CR: begin
                    if (!pend) begin
                        wr    <= 1'b1;
                        addr  <= A_CR;
                        wdata <= cr_q;
                        pend  <= 1'b1;
                    end else if (cmd_done) begin
                        pend  <= 1'b0;
                        state <= RD_SR;
                    end
                end
                RD_SR: begin
                    if (!pend) begin
                        rd   <= 1'b1;
                        addr <= A_SR;
                        pend <= 1'b1;
                    end else if (cmd_rdata_valid) begin
                        tip_q   <= cmd_rdata[SR_TIP];
                        rxack_q <= cmd_rdata[SR_RXACK];
                        pend    <= 1'b0;
                        state   <= CHK_SR;
                    end
                end
                CHK_SR: begin
                    // RxACK is only meaningful once TIP has cleared
                    if (tip_q) begin
                        if (poll == POLL_LIMIT) begin
                            timeout <= 1'b1;
                            state   <= X_IDLE;
                        end else begin
                            poll  <= poll + 10'd1;
                            state <= RD_SR;
                        end
                    end else if (rxack_q) begin
                        nack  <= 1'b1;
                        state <= X_IDLE;
                    end else begin
                        done  <= 1'b1;
                        state <= X_IDLE;
                    end
                end
                default: state <= X_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/codec_i2c_write_sequencer.sv
// Codec register writer over an I2C core: init, 3-byte write, STO abort.
// Ports: req_* handshake, cmd_* core bus, busy/done/error status.
module codec_i2c_write_sequencer
    import codec_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter logic [15:0] PRESCALE   = 16'd199,
    parameter logic [9:0]  POLL_LIMIT = 10'd1023
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_reg_addr,
    input  logic [8:0] req_reg_data,
    output logic       cmd_write,
    output logic       cmd_read,
    output logic [3:0] cmd_addr,
    output logic [7:0] cmd_data,
    input  logic       cmd_done,
    input  logic [7:0] cmd_rdata,
    input  logic       cmd_rdata_valid,
    output logic       busy,
    output logic       done,
    output logic       error
);

    seq_state_t state;
    seq_state_t t_next;
    logic       in_reset;
    logic       pend;
    logic [6:0] reg_addr_q;
    logic [8:0] reg_data_q;
    logic [1:0] idx;

    logic       t_cmd;
    logic       t_wr;
    logic [3:0] t_addr;
    logic [7:0] t_data;
    logic [3:0] t_addr_n;
    logic [7:0] t_data_n;

    logic       x_start;
    logic [7:0] x_byte;
    logic [7:0] x_cr;
    logic       x_wr;
    logic       x_rd;
    logic [3:0] x_addr;
    logic [7:0] x_wdata;
    logic       x_done;
    logic       x_nack;
    logic       x_timeout;

    // Keeps busy low in the cycle right after a reset edge
    always_ff @(posedge clk) begin
        in_reset <= ~reset_n;
    end

    assign req_ready = (state == IDLE);
    assign busy      = ~in_reset & (state != IDLE);

    // Core-register writes owned by this level: init and abort
    always_comb begin
        t_cmd    = 1'b0;
        t_addr_n = A_PRER_LO;
        t_data_n = 8'h00;
        t_next   = state;
        unique case (state)
            INIT_PRER_LO: begin
                t_cmd    = 1'b1;
                t_addr_n = A_PRER_LO;
                t_data_n = PRESCALE[7:0];
                t_next   = INIT_PRER_HI;
            end
            INIT_PRER_HI: begin
                t_cmd    = 1'b1;
                t_addr_n = A_PRER_HI;
                t_data_n = PRESCALE[15:8];
                t_next   = INIT_CTR;
            end
            INIT_CTR: begin
                t_cmd    = 1'b1;
                t_addr_n = A_CTR;
                t_data_n = CTR_EN;
                t_next   = IDLE;
            end
            ABORT: begin
                t_cmd    = 1'b1;
                t_addr_n = A_CR;
                t_data_n = CR_STO;
                t_next   = IDLE;
            end
            default: ;
        endcase
    end

    // Byte and command selection for the current byte index
    always_comb begin
        x_byte = 8'h00;
        x_cr   = CR_WR;
        unique case (idx)
            2'd0: begin
                x_byte = {DEV_ADDR, 1'b0};
                x_cr   = CR_STA_WR;
            end
            2'd1: begin
                x_byte = {reg_addr_q, reg_data_q[8]};
                x_cr   = CR_WR;
            end
            2'd2: begin
                x_byte = reg_data_q[7:0];
                x_cr   = CR_STO_WR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= INIT_PRER_LO;
            pend       <= 1'b0;
            t_wr       <= 1'b0;
            t_addr     <= 4'd0;
            t_data     <= 8'h00;
            reg_addr_q <= 7'd0;
            reg_data_q <= 9'd0;
            idx        <= 2'd0;
            x_start    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            t_wr    <= 1'b0;
            x_start <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            if (t_cmd) begin
                if (!pend) begin
                    t_wr   <= 1'b1;
                    t_addr <= t_addr_n;
                    t_data <= t_data_n;
                    pend   <= 1'b1;
                end else if (cmd_done) begin
                    pend  <= 1'b0;
                    state <= t_next;
                    error <= (state == ABORT);
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (req_valid) begin
                            reg_addr_q <= req_reg_addr;
                            reg_data_q <= req_reg_data;
                            idx        <= 2'd0;
                            x_start    <= 1'b1;
                            state      <= XFER;
                        end
                    end
                    XFER: begin
                        if (x_done) begin
                            if (idx == 2'd2) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                idx     <= idx + 2'd1;
                                x_start <= 1'b1;
                            end
                        end else if (x_nack || x_timeout) begin
                            state <= ABORT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    codec_i2c_byte_xfer #(
        .POLL_LIMIT(POLL_LIMIT)
    ) u_xfer (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (x_start),
        .tx_byte        (x_byte),
        .cr             (x_cr),
        .cmd_done       (cmd_done),
        .cmd_rdata      (cmd_rdata),
        .cmd_rdata_valid(cmd_rdata_valid),
        .wr             (x_wr),
        .rd             (x_rd),
        .addr           (x_addr),
        .wdata          (x_wdata),
        .done           (x_done),
        .nack           (x_nack),
        .timeout        (x_timeout)
    );

    // Only one side is ever issuing, so pulses can be ORed
    assign cmd_write = t_wr | x_wr;
    assign cmd_read  = x_rd;
    assign cmd_addr  = (state == XFER) ? x_addr : t_addr;
    assign cmd_data  = (state == XFER) ? x_wdata : t_data;

endmodule

// File: tb/tb_codec_i2c_write_sequencer.sv
// Scoreboard bench for codec_i2c_write_sequencer with a responder model.
// Expected core-bus events come from a transaction-level plan per request.
module tb_codec_i2c_write_sequencer;

    localparam logic [6:0]  DEV = 7'h1A;
    localparam logic [15:0] PRE = 16'd199;
    localparam int          LIM = 4;

    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_RD  = 2'd1;
    localparam logic [1:0] K_DN  = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_reg_addr;
    logic [8:0] req_reg_data;
    logic       cmd_write;
    logic       cmd_read;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_done;
    logic [7:0] cmd_rdata;
    logic       cmd_rdata_valid;
    logic       busy;
    logic       done;
    logic       error;

    ev_t        exp_q[$];
    logic [7:0] sr_q[$];
    int         total = 0;
    int         bad = 0;
    int         n_pop = 0;
    int         tip_n[3];
    bit         nack_b[3];
    bit         inj_done = 0;
    bit         inj_rv = 0;

    always #5 clk = ~clk;

    codec_i2c_write_sequencer #(
        .DEV_ADDR  (DEV),
        .PRESCALE  (PRE),
        .POLL_LIMIT(10'(LIM))
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_reg_addr   (req_reg_addr),
        .req_reg_data   (req_reg_data),
        .cmd_write      (cmd_write),
        .cmd_read       (cmd_read),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .cmd_done       (cmd_done),
        .cmd_rdata      (cmd_rdata),
        .cmd_rdata_valid(cmd_rdata_valid),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    function automatic ev_t mk(input logic [1:0] k,
                               input logic [3:0] a,
                               input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    function automatic logic [7:0] tip_val();
        logic [7:0] v;
        v = 8'($urandom) | 8'h02;
        return v;
    endfunction

    // Transaction-level plan: bytes, CR codes, SR polls, abort
    task automatic plan_txn(input logic [6:0] ra, input logic [8:0] rdt);
        logic [7:0] bytes[3];
        logic [7:0] crs[3];
        logic [7:0] v;
        bytes[0] = {DEV, 1'b0};
        bytes[1] = {ra, rdt[8]};
        bytes[2] = rdt[7:0];
        crs[0] = 8'h90;
        crs[1] = 8'h10;
        crs[2] = 8'h50;
        for (int b = 0; b < 3; b++) begin
            exp_q.push_back(mk(K_WR, 4'd3, bytes[b]));
            exp_q.push_back(mk(K_WR, 4'd4, crs[b]));
            if (tip_n[b] > LIM) begin
                for (int i = 0; i <= LIM; i++) begin
                    exp_q.push_back(mk(K_RD, 4'd4, 8'h00));
                    sr_q.push_back(tip_val());
                end
                exp_q.push_back(mk(K_WR, 4'd4, 8'h40));
                exp_q.push_back(mk(K_ERR, 4'd0, 8'h00));
                return;
            end
            for (int i = 0; i < tip_n[b]; i++) begin
                exp_q.push_back(mk(K_RD, 4'd4, 8'h00));
                sr_q.push_back(tip_val());
            end
            exp_q.push_back(mk(K_RD, 4'd4, 8'h00));
            v = 8'($urandom) & 8'h7D;
            if (nack_b[b]) v = v | 8'h80;
            sr_q.push_back(v);
            if (nack_b[b]) begin
                exp_q.push_back(mk(K_WR, 4'd4, 8'h40));
                exp_q.push_back(mk(K_ERR, 4'd0, 8'h00));
                return;
            end
        end
        exp_q.push_back(mk(K_DN, 4'd0, 8'h00));
    endtask

    task automatic got(input logic [1:0] k,
                       input logic [3:0] a,
                       input logic [7:0] d);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got kind=%0d a=%0h d=%0h want none",
                     k, a, d);
        end else begin
            e = exp_q.pop_front();
            n_pop++;
            if (e.kind !== k || e.addr !== a ||
                (k == K_WR && e.data !== d)) begin
                bad++;
                $display("FAIL event got kind=%0d a=%0h d=%0h want kind=%0d a=%0h d=%0h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: sample after the active edge
    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            total++;
            if (req_ready === busy || (done && error)) begin
                bad++;
                $display("FAIL status got ready=%b busy=%b done=%b err=%b want busy=~ready, not done&err",
                         req_ready, busy, done, error);
            end
            if (cmd_write) got(K_WR, cmd_addr, cmd_data);
            if (cmd_read)  got(K_RD, cmd_addr, 8'h00);
            if (done)      got(K_DN, 4'd0, 8'h00);
            if (error)     got(K_ERR, 4'd0, 8'h00);
        end
    end

    // Core responder: write ack 2 cycles later, SR read after 1..3 cycles
    initial begin
        int wdly;
        int rdly;
        wdly = 0;
        rdly = 0;
        cmd_done = 1'b0;
        cmd_rdata_valid = 1'b0;
        cmd_rdata = 8'h00;
        forever begin
            @(negedge clk);
            cmd_done = 1'b0;
            cmd_rdata_valid = 1'b0;
            if (!reset_n) begin
                wdly = 0;
                rdly = 0;
            end else begin
                if (wdly > 0) begin
                    wdly--;
                    if (wdly == 0) cmd_done = 1'b1;
                end
                if (rdly > 0) begin
                    rdly--;
                    if (rdly == 0) begin
                        cmd_rdata_valid = 1'b1;
                        if (sr_q.size() > 0) begin
                            cmd_rdata = sr_q.pop_front();
                        end else begin
                            cmd_rdata = 8'h00;
                            total++;
                            bad++;
                            $display("FAIL sr_underflow got extra SR read want none");
                        end
                    end
                end
                if (cmd_write) wdly = 2;
                if (cmd_read)  rdly = $urandom_range(1, 3);
            end
            if (inj_done) begin
                cmd_done = 1'b1;
                inj_done = 0;
            end
            if (inj_rv) begin
                cmd_rdata_valid = 1'b1;
                cmd_rdata = 8'h00;
                inj_rv = 0;
            end
        end
    end

    task automatic check_zero();
        logic [15:0] v;
        v = {req_ready, busy, done, error, cmd_write, cmd_read,
             cmd_addr, cmd_data};
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs got %h want 0000", v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        sr_q.delete();
        @(posedge clk);
        #2;
        check_zero();
        repeat (3) @(negedge clk);
        exp_q.push_back(mk(K_WR, 4'd0, PRE[7:0]));
        exp_q.push_back(mk(K_WR, 4'd1, PRE[15:8]));
        exp_q.push_back(mk(K_WR, 4'd2, 8'h80));
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && req_ready) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s idle_timeout got pending=%0d ready=%b want 0 and 1",
                     nm, exp_q.size(), req_ready);
            exp_q.delete();
        end
        total++;
        if (sr_q.size() != 0) begin
            bad++;
            $display("FAIL %s sr_left got %0d want 0", nm, sr_q.size());
            sr_q.delete();
        end
    endtask

    task automatic send(input logic [6:0] a, input logic [8:0] d,
                        input bit hold);
        plan_txn(a, d);
        @(negedge clk);
        req_valid = 1'b1;
        req_reg_addr = a;
        req_reg_data = d;
        @(negedge clk);
        if (hold) begin
            for (int i = 0; i < 4000 && !req_ready; i++) begin
                req_reg_addr = 7'($urandom);
                req_reg_data = 9'($urandom);
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        req_reg_addr = 7'($urandom);
        req_reg_data = 9'($urandom);
    endtask

    task automatic set_plan(input int t0, input int t1, input int t2,
                            input bit n0, input bit n1, input bit n2);
        tip_n[0] = t0;
        tip_n[1] = t1;
        tip_n[2] = t2;
        nack_b[0] = n0;
        nack_b[1] = n1;
        nack_b[2] = n2;
    endtask

    initial begin
        int base;
        bit hit;
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_reg_addr = 7'd0;
        req_reg_data = 9'd0;

        do_reset();
        wait_idle("init");

        set_plan(2, 2, 2, 0, 0, 0);
        send(7'h06, 9'h0F0, 0);
        wait_idle("polled_write");

        set_plan(0, 0, 0, 1, 0, 0);
        send(7'h11, 9'h155, 0);
        wait_idle("nack_byte1");

        set_plan(9, 0, 0, 0, 0, 0);
        send(7'h22, 9'h0AA, 0);
        wait_idle("poll_timeout");

        set_plan(LIM, 0, 1, 0, 0, 0);
        send(7'h7F, 9'h1FF, 0);
        wait_idle("poll_at_limit");

        inj_done = 1;
        repeat (3) @(negedge clk);
        set_plan(1, 0, 0, 0, 0, 0);
        send(7'h33, 9'h101, 1);
        wait_idle("held_valid");

        set_plan(0, 0, 0, 0, 0, 1);
        send(7'h44, 9'h0C3, 1);
        wait_idle("held_valid_nack3");

        for (int n = 0; n < 20; n++) begin
            for (int b = 0; b < 3; b++) begin
                tip_n[b] = $urandom_range(0, 5);
                nack_b[b] = ($urandom_range(0, 7) == 0);
            end
            send(7'($urandom), 9'($urandom), bit'($urandom_range(0, 1)));
            wait_idle("random");
        end

        set_plan(0, 4, 0, 0, 0, 0);
        base = n_pop;
        send(7'h55, 9'h0E1, 0);
        hit = 0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge clk);
            if (n_pop >= base + 7) hit = 1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL reset_mid reach_byte2 got pops=%0d want %0d",
                     n_pop - base, 7);
        end
        do_reset();
        inj_rv = 1;
        wait_idle("reinit");

        set_plan(1, 1, 1, 0, 0, 0);
        send(7'h06, 9'h0F0, 0);
        wait_idle("after_reset");

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
